// File: rtl/alarm_bank.sv
// Multi-slot BCD alarm bank with ring/snooze/timeout controller.
// Define ALARM_BANK_SNOOZE_EN to build the snooze input and SNOOZED state.
module alarm_bank #(
   parameter int NUM_ALARMS = 4,
   parameter int SNOOZE_MIN = 5,
   parameter int RING_MIN   = 2,
   localparam int IDX_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ld_alarm,
   input  logic [IDX_W-1:0] ld_idx,
   input  logic             ld_en,
   input  logic [1:0]       H_in1,
   input  logic [3:0]       H_in0,
   input  logic [3:0]       M_in1,
   input  logic [3:0]       M_in0,
   input  logic [1:0]       c_hour1,
   input  logic [3:0]       c_hour0,
   input  logic [3:0]       c_min1,
   input  logic [3:0]       c_min0,
   input  logic             min_tick,
   input  logic             stop,
   input  logic             snooze,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [1:0]       rd_hour1,
   output logic [3:0]       rd_hour0,
   output logic [3:0]       rd_min1,
   output logic [3:0]       rd_min0,
   output logic             rd_en,
   output logic             ring,
   output logic [IDX_W-1:0] ring_idx,
   output logic             ld_err
);

   // Storage covers the full index space; slots past NUM_ALARMS are never
   // written, so they read back as a disabled 00:00 and never match.
   localparam int DEPTH = 1 << IDX_W;
   localparam logic [IDX_W:0] NA = (IDX_W + 1)'(NUM_ALARMS);
   localparam logic [3:0] RING_LAST = 4'(RING_MIN - 1);

   logic [1:0] h1_q [DEPTH];
   logic [3:0] h0_q [DEPTH];
   logic [3:0] m1_q [DEPTH];
   logic [3:0] m0_q [DEPTH];
   logic       en_q [DEPTH];

   logic hr_ok, mn_ok, idx_ok, ld_ok;

   always_comb begin
      hr_ok  = ((H_in1 < 2'd2) && (H_in0 <= 4'd9)) ||
               ((H_in1 == 2'd2) && (H_in0 <= 4'd3));
      mn_ok  = (M_in1 <= 4'd5) && (M_in0 <= 4'd9);
      idx_ok = ({1'b0, ld_idx} < NA);
      ld_ok  = hr_ok && mn_ok && idx_ok;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            h1_q[i] <= '0;
            h0_q[i] <= '0;
            m1_q[i] <= '0;
            m0_q[i] <= '0;
            en_q[i] <= 1'b0;
         end
         ld_err <= 1'b0;
      end else begin
         ld_err <= ld_alarm && !ld_ok;
         if (ld_alarm && ld_ok) begin
            h1_q[ld_idx] <= H_in1;
            h0_q[ld_idx] <= H_in0;
            m1_q[ld_idx] <= M_in1;
            m0_q[ld_idx] <= M_in0;
            en_q[ld_idx] <= ld_en;
         end
      end
   end

   assign rd_hour1 = h1_q[rd_idx];
   assign rd_hour0 = h0_q[rd_idx];
   assign rd_min1  = m1_q[rd_idx];
   assign rd_min0  = m0_q[rd_idx];
   assign rd_en    = en_q[rd_idx];

   logic             hit;
   logic [IDX_W-1:0] hit_idx;

   // Scan high to low so the lowest matching slot is the one left standing.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (en_q[i] &&
             h1_q[i] == c_hour1 && h0_q[i] == c_hour0 &&
             m1_q[i] == c_min1  && m0_q[i] == c_min0) begin
            hit     = 1'b1;
            hit_idx = i[IDX_W-1:0];
         end
      end
   end

`ifdef ALARM_BANK_SNOOZE_EN
   localparam logic [3:0] SNZ_LAST = 4'(SNOOZE_MIN - 1);
   typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_t;
`else
   typedef enum logic [1:0] {IDLE, RINGING} state_t;
   logic unused_snooze;
   assign unused_snooze = snooze;
`endif

   state_t           state, state_n;
   logic [3:0]       mcnt, mcnt_n;
   logic [IDX_W-1:0] ridx_n;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         mcnt     <= '0;
         ring_idx <= '0;
      end else begin
         state    <= state_n;
         mcnt     <= mcnt_n;
         ring_idx <= ridx_n;
      end
   end

   always_comb begin
      state_n = state;
      mcnt_n  = mcnt;
      ridx_n  = ring_idx;
      unique case (state)
         IDLE: begin
            if (min_tick && hit) begin
               state_n = RINGING;
               mcnt_n  = '0;
               ridx_n  = hit_idx;
            end
         end
         RINGING: begin
            if (stop) begin
               state_n = IDLE;
               mcnt_n  = '0;
`ifdef ALARM_BANK_SNOOZE_EN
            end else if (snooze) begin
               state_n = SNOOZED;
               mcnt_n  = '0;
`endif
            end else if (min_tick) begin
               if (mcnt == RING_LAST) begin
                  state_n = IDLE;
                  mcnt_n  = '0;
               end else begin
                  mcnt_n = mcnt + 4'd1;
               end
            end
         end
`ifdef ALARM_BANK_SNOOZE_EN
         SNOOZED: begin
            if (stop) begin
               state_n = IDLE;
               mcnt_n  = '0;
            end else if (min_tick) begin
               if (mcnt == SNZ_LAST) begin
                  state_n = RINGING;
                  mcnt_n  = '0;
               end else begin
                  mcnt_n = mcnt + 4'd1;
               end
            end
         end
`endif
         default: begin
            state_n = IDLE;
            mcnt_n  = '0;
         end
      endcase
   end

   assign ring = (state == RINGING);

endmodule

// File: tb/tb_alarm_bank.sv
// Scoreboard bench for alarm_bank: expectations queued with stimulus,
// popped and compared once the DUT has settled after each edge.
module tb_alarm_bank;

   localparam int NA = 3;
   localparam int IW = 2;

   logic          clk, reset;
   logic          ld_alarm, ld_en;
   logic [IW-1:0] ld_idx, rd_idx;
   logic [1:0]    H_in1, c_hour1;
   logic [3:0]    H_in0, M_in1, M_in0;
   logic [3:0]    c_hour0, c_min1, c_min0;
   logic          min_tick, stop, snooze;
   logic [1:0]    rd_hour1;
   logic [3:0]    rd_hour0, rd_min1, rd_min0;
   logic          rd_en, ring, ld_err;
   logic [IW-1:0] ring_idx;

   alarm_bank #(.NUM_ALARMS(NA)) dut (
      .clk(clk), .reset(reset),
      .ld_alarm(ld_alarm), .ld_idx(ld_idx), .ld_en(ld_en),
      .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
      .c_hour1(c_hour1), .c_hour0(c_hour0),
      .c_min1(c_min1), .c_min0(c_min0),
      .min_tick(min_tick), .stop(stop), .snooze(snooze),
      .rd_idx(rd_idx),
      .rd_hour1(rd_hour1), .rd_hour0(rd_hour0),
      .rd_min1(rd_min1), .rd_min0(rd_min0), .rd_en(rd_en),
      .ring(ring), .ring_idx(ring_idx), .ld_err(ld_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      int          sel;
      logic [14:0] exp;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   function automatic logic [14:0] obs(int sel);
      case (sel)
         0:       return {14'd0, ring};
         1:       return {13'd0, ring_idx};
         2:       return {14'd0, ld_err};
         default: return {rd_en, rd_hour1, rd_hour0, rd_min1, rd_min0};
      endcase
   endfunction

   function automatic logic [14:0] slot(logic e, logic [1:0] h1,
         logic [3:0] h0, logic [3:0] m1, logic [3:0] m0);
      return {e, h1, h0, m1, m0};
   endfunction

   task automatic check(string tag, logic [14:0] got, logic [14:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %h want %h", tag, got, want);
   endtask

   task automatic want(string tag, int sel, logic [14:0] v);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = v;
      sb.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check(e.tag, obs(e.sel), e.exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      drain();
   endtask

   task automatic rd_chk(string tag, logic [IW-1:0] idx, logic [14:0] v);
      rd_idx = idx;
      want(tag, 3, v);
      #1;
      drain();
   endtask

   task automatic load(string tag, logic [IW-1:0] idx, logic e,
         logic [1:0] h1, logic [3:0] h0, logic [3:0] m1, logic [3:0] m0,
         logic bad);
      ld_alarm = 1'b1;
      ld_idx   = idx;
      ld_en    = e;
      H_in1    = h1;
      H_in0    = h0;
      M_in1    = m1;
      M_in0    = m0;
      want(tag, 2, {14'd0, bad});
      step();
      ld_alarm = 1'b0;
   endtask

   task automatic tick(logic [1:0] h1, logic [3:0] h0,
         logic [3:0] m1, logic [3:0] m0);
      c_hour1  = h1;
      c_hour0  = h0;
      c_min1   = m1;
      c_min0   = m0;
      min_tick = 1'b1;
      step();
      min_tick = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      ld_alarm = 0; ld_idx = 0; ld_en = 0;
      H_in1 = 0; H_in0 = 0; M_in1 = 0; M_in0 = 0;
      c_hour1 = 0; c_hour0 = 0; c_min1 = 0; c_min0 = 0;
      min_tick = 0; stop = 0; snooze = 0; rd_idx = 0;
      #3;
      want("rst_ring", 0, 15'd0);
      want("rst_ridx", 1, 15'd0);
      want("rst_lderr", 2, 15'd0);
      drain();
      rd_chk("rst_slot0", 2'd0, 15'd0);
      @(negedge clk);
      reset = 1'b0;

      load("ld_0730", 2'd1, 1'b1, 2'd0, 4'd7, 4'd3, 4'd0, 1'b0);
      rd_chk("rd_0730", 2'd1, slot(1, 0, 7, 3, 0));
      want("match_ring", 0, 15'd1);
      want("match_idx", 1, 15'd1);
      tick(2'd0, 4'd7, 4'd3, 4'd0);
      stop = 1'b1;
      want("stop_ring", 0, 15'd0);
      step();
      stop = 1'b0;

      load("ld_2400", 2'd1, 1'b1, 2'd2, 4'd4, 4'd0, 4'd0, 1'b1);
      want("lderr_clr", 2, 15'd0);
      step();
      load("ld_1260", 2'd1, 1'b1, 2'd1, 4'd2, 4'd6, 4'd0, 1'b1);
      load("ld_3000", 2'd1, 1'b1, 2'd3, 4'd0, 4'd0, 4'd0, 1'b1);
      load("ld_idx3", 2'd3, 1'b1, 2'd1, 4'd0, 4'd0, 4'd0, 1'b1);
      rd_chk("rd_keep", 2'd1, slot(1, 0, 7, 3, 0));
      rd_chk("rd_idx3", 2'd3, 15'd0);
      load("ld_2359", 2'd2, 1'b0, 2'd2, 4'd3, 4'd5, 4'd9, 1'b0);
      rd_chk("rd_2359", 2'd2, slot(0, 2, 3, 5, 9));

      load("ld_s0", 2'd0, 1'b1, 2'd0, 4'd6, 4'd0, 4'd0, 1'b0);
      load("ld_s2", 2'd2, 1'b1, 2'd0, 4'd6, 4'd0, 4'd0, 1'b0);
      want("prio_ring", 0, 15'd1);
      want("prio_idx", 1, 15'd0);
      tick(2'd0, 4'd6, 4'd0, 4'd0);
      stop = 1'b1;
      want("prio_stop", 0, 15'd0);
      step();
      stop = 1'b0;

      want("snz_ring", 0, 15'd1);
      tick(2'd0, 4'd6, 4'd0, 4'd0);
      snooze = 1'b1;
`ifdef ALARM_BANK_SNOOZE_EN
      want("snz_off", 0, 15'd0);
      step();
      snooze = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         want("snz_wait", 0, 15'd0);
         tick(2'd0, 4'd6, 4'd0, 4'(i));
      end
      want("snz_back", 0, 15'd1);
      tick(2'd0, 4'd6, 4'd0, 4'd5);
      want("snz_ring1", 0, 15'd1);
      tick(2'd0, 4'd6, 4'd0, 4'd6);
      want("snz_tmo", 0, 15'd0);
      tick(2'd0, 4'd6, 4'd0, 4'd7);
`else
      want("snz_ignored", 0, 15'd1);
      step();
      snooze = 1'b0;
      want("tmo_ring1", 0, 15'd1);
      tick(2'd0, 4'd6, 4'd0, 4'd1);
      want("tmo_off", 0, 15'd0);
      tick(2'd0, 4'd6, 4'd0, 4'd2);
`endif

      ld_alarm = 1'b1; ld_idx = 2'd0; ld_en = 1'b0;
      H_in1 = 2'd0; H_in0 = 4'd6; M_in1 = 4'd0; M_in0 = 4'd0;
      want("same_ring", 0, 15'd1);
      want("same_idx", 1, 15'd0);
      tick(2'd0, 4'd6, 4'd0, 4'd0);
      ld_alarm = 1'b0;
      rd_chk("same_rd", 2'd0, slot(0, 0, 6, 0, 0));
      stop = 1'b1;
      snooze = 1'b1;
      want("both_off", 0, 15'd0);
      step();
      stop = 1'b0;
      snooze = 1'b0;

      want("s2_ring", 0, 15'd1);
      want("s2_idx", 1, 15'd2);
      tick(2'd0, 4'd6, 4'd0, 4'd0);
      want("busy_ring", 0, 15'd1);
      want("busy_idx", 1, 15'd2);
      tick(2'd0, 4'd7, 4'd3, 4'd0);

      #2;
      reset = 1'b1;
      #1;
      want("arst_ring", 0, 15'd0);
      want("arst_idx", 1, 15'd0);
      drain();
      for (int i = 0; i < 4; i++) rd_chk("arst_slot", 2'(i), 15'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
